// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for a synchronous FIFO: wrapping (K+1)-bit read/write
// pointers, occupancy count, registered status flags, sticky errors and Gray pointer copies.
module fifo_ptr_ctrl #(
  parameter int K      = 4,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic         wr_ok,
  output logic         rd_ok,
  output logic [K-1:0] wr_addr,
  output logic [K-1:0] rd_addr,
  output logic [K:0]   wr_ptr_gray,
  output logic [K:0]   rd_ptr_gray,
  output logic [K:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [K:0] DEPTH = {1'b1, {K{1'b0}}};
  localparam logic [K:0] ONE   = {{K{1'b0}}, 1'b1};
  localparam logic [K:0] AF    = AF_LVL[K:0];
  localparam logic [K:0] AE    = AE_LVL[K:0];

  logic [K:0] wr_ptr, rd_ptr;
  logic [K:0] wr_ptr_n, rd_ptr_n, count_n;

  // Acceptance depends only on registered flags, so wr_en never reaches rd_ok and vice versa.
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign wr_addr = wr_ptr[K-1:0];
  assign rd_addr = rd_ptr[K-1:0];

  always_comb begin
    wr_ptr_n = wr_ok ? wr_ptr + ONE : wr_ptr;
    rd_ptr_n = rd_ok ? rd_ptr + ONE : rd_ptr;
    count_n  = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_n = count + ONE;
      2'b01:   count_n = count - ONE;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_ptr_gray  <= '0;
      rd_ptr_gray  <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_ptr_gray  <= '0;
      rd_ptr_gray  <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      wr_ptr_gray  <= wr_ptr_n ^ (wr_ptr_n >> 1);
      rd_ptr_gray  <= rd_ptr_n ^ (rd_ptr_n >> 1);
      count        <= count_n;
      // Flags decode the next count so they line up with count in the same cycle.
      full         <= (count_n == DEPTH);
      empty        <= (count_n == '0);
      almost_full  <= (count_n >= AF);
      almost_empty <= (count_n <= AE);
      overflow     <= overflow | (wr_en & full);
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl (K=4): stimulus pushes expected per-cycle state,
// a monitor pops and compares it against the DUT mid-cycle.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       wr_ok, rd_ok;
  logic [3:0] wr_addr, rd_addr;
  logic [4:0] wr_ptr_gray, rd_ptr_gray, count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       wok, rok;
    logic [3:0] wa, ra;
    logic [4:0] wg, rg, cnt;
    logic       full, empty, af, ae, ov, ud;
  } exp_t;

  exp_t sb[$];

  int mwp = 0, mrp = 0;
  bit mov = 0, mud = 0;

  fifo_ptr_ctrl #(.K(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_ok(wr_ok), .rd_ok(rd_ok), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: drive inputs at negedge, queue the state expected before
  // the next posedge, then advance the reference model across that edge.
  task automatic step(input string tag, input bit w, input bit r, input bit c, input bit rs);
    exp_t e;
    int   cnt;
    @(negedge clk);
    wr_en = w; rd_en = r; clr = c; rst = rs;
    if (rs) begin mwp = 0; mrp = 0; mov = 0; mud = 0; end
    cnt     = (((mwp - mrp) % 32) + 32) % 32;
    e.tag   = tag;
    e.cnt   = 5'(cnt);
    e.full  = (cnt == 16);
    e.empty = (cnt == 0);
    e.af    = (cnt >= 14);
    e.ae    = (cnt <= 2);
    e.wok   = w && (cnt != 16);
    e.rok   = r && (cnt != 0);
    e.wa    = 4'(mwp % 16);
    e.ra    = 4'(mrp % 16);
    e.wg    = 5'(mwp ^ (mwp >> 1));
    e.rg    = 5'(mrp ^ (mrp >> 1));
    e.ov    = mov;
    e.ud    = mud;
    sb.push_back(e);
    if (!rs) begin
      if (c) begin
        mwp = 0; mrp = 0; mov = 0; mud = 0;
      end else begin
        if (w && cnt == 16) mov = 1;
        if (r && cnt == 0)  mud = 1;
        if (e.wok) mwp = (mwp + 1) % 32;
        if (e.rok) mrp = (mrp + 1) % 32;
      end
    end
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d (t=%0t)", tag, fld, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.tag, "wr_ok",        8'(wr_ok),        8'(e.wok));
        cmp(e.tag, "rd_ok",        8'(rd_ok),        8'(e.rok));
        cmp(e.tag, "wr_addr",      8'(wr_addr),      8'(e.wa));
        cmp(e.tag, "rd_addr",      8'(rd_addr),      8'(e.ra));
        cmp(e.tag, "wr_ptr_gray",  8'(wr_ptr_gray),  8'(e.wg));
        cmp(e.tag, "rd_ptr_gray",  8'(rd_ptr_gray),  8'(e.rg));
        cmp(e.tag, "count",        8'(count),        8'(e.cnt));
        cmp(e.tag, "full",         8'(full),         8'(e.full));
        cmp(e.tag, "empty",        8'(empty),        8'(e.empty));
        cmp(e.tag, "almost_full",  8'(almost_full),  8'(e.af));
        cmp(e.tag, "almost_empty", 8'(almost_empty), 8'(e.ae));
        cmp(e.tag, "overflow",     8'(overflow),     8'(e.ov));
        cmp(e.tag, "underflow",    8'(underflow),    8'(e.ud));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    step("reset", 0, 0, 0, 1);
    step("release", 0, 0, 0, 0);
    repeat (7) step("pre_wr", 1, 0, 0, 0);
    step("hold7", 0, 0, 0, 0);
    // rst rises at negedge; the monitor samples before the next posedge
    step("async_rst", 1, 0, 0, 1);
    step("release2", 0, 0, 0, 0);
    repeat (16) step("fill", 1, 0, 0, 0);
    step("wr17", 1, 0, 0, 0);
    step("ovf_seen", 0, 0, 0, 0);
    repeat (16) step("drain", 0, 1, 0, 0);
    step("rd17", 0, 1, 0, 0);
    repeat (3) step("udf_sticky", 0, 0, 0, 0);
    step("both_empty", 1, 1, 0, 0);
    step("after_be", 0, 0, 0, 0);
    repeat (15) step("refill", 1, 0, 0, 0);
    step("both_full", 1, 1, 0, 0);
    step("after_bf", 0, 0, 0, 0);
    repeat (7) step("to8", 0, 1, 0, 0);
    repeat (40) step("both8", 1, 1, 0, 0);
    step("after_b8", 0, 0, 0, 0);
    step("to9", 1, 0, 0, 0);
    step("clr_wr", 1, 0, 1, 0);
    step("after_clr", 0, 0, 0, 0);
    step("gray_w", 1, 0, 0, 0);
    repeat (31) step("gray_both", 1, 1, 0, 0);
    step("gray_wrap", 0, 0, 0, 0);
    step("final", 0, 0, 0, 0);
    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
